// File: rtl/fir_poly_mac.sv
// Polyphase FIR engine: one shared multiply-accumulate unit walks
// N_TAPS taps for each of N_PHASE coefficient banks per input sample.
module fir_poly_mac #(
    parameter  int W_IN    = 7,
    parameter  int W_COEF  = 5,
    parameter  int W_OUT   = 20,
    parameter  int N_TAPS  = 4,
    parameter  int N_PHASE = 6,
    localparam int W_CA    = $clog2(N_PHASE * N_TAPS),
    localparam int W_PH    = (N_PHASE > 1) ? $clog2(N_PHASE) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN-1:0]   in_data,
    input  logic              coef_we,
    input  logic [W_CA-1:0]   coef_addr,
    input  logic [W_COEF-1:0] coef_wdata,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_OUT-1:0]  out_data,
    output logic [W_PH-1:0]   out_phase,
    output logic              out_sat
);

    localparam int W_ACC  = W_IN + W_COEF + $clog2(N_TAPS);
    localparam int W_TAP  = $clog2(N_TAPS);
    localparam int N_COEF = N_PHASE * N_TAPS;
    // Wide enough to hold both the accumulator and the output limits.
    localparam int W_BIG  = ((W_ACC > W_OUT) ? W_ACC : W_OUT) + 1;

    localparam logic signed [W_BIG-1:0] ONE    = W_BIG'(1);
    localparam logic signed [W_BIG-1:0] LIM_HI = (ONE <<< (W_OUT - 1)) - ONE;
    localparam logic signed [W_BIG-1:0] LIM_LO = -(ONE <<< (W_OUT - 1));
    localparam logic [W_TAP-1:0]        TAP_LAST = W_TAP'(N_TAPS - 1);
    localparam logic [W_PH-1:0]         PH_LAST  = W_PH'(N_PHASE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [W_IN-1:0]   x    [N_TAPS];
    logic signed [W_COEF-1:0] coef [N_COEF];

    logic [W_TAP-1:0]        tap;
    logic [W_PH-1:0]         phase;
    logic signed [W_ACC-1:0] acc;

    logic                    accept;
    logic                    handshake;
    logic                    last_tap;
    logic                    last_phase;
    logic                    coef_wr;
    logic [W_CA-1:0]         cidx;
    logic signed [W_ACC-1:0] xs;
    logic signed [W_ACC-1:0] cs;
    logic signed [W_ACC-1:0] prod;
    logic signed [W_ACC-1:0] sum;
    logic signed [W_BIG-1:0] sum_big;
    logic [W_OUT-1:0]        sat_data;
    logic                    sat_flag;

    assign accept     = in_valid & in_ready & ~clear;
    assign handshake  = out_valid & out_ready;
    assign last_tap   = (tap == TAP_LAST);
    assign last_phase = (phase == PH_LAST);
    assign coef_wr    = coef_we & (state == S_IDLE) & ~clear
                      & (32'(coef_addr) < N_COEF);

    // Full-precision product and running sum, then clamp to the output range.
    always_comb begin
        cidx     = W_CA'(32'(phase) * N_TAPS + 32'(tap));
        xs       = W_ACC'(x[tap]);
        cs       = W_ACC'(coef[cidx]);
        prod     = xs * cs;
        sum      = acc + prod;
        sum_big  = W_BIG'(sum);
        sat_data = W_OUT'(sum_big);
        sat_flag = 1'b0;
        if (sum_big > LIM_HI) begin
            sat_data = W_OUT'(LIM_HI);
            sat_flag = 1'b1;
        end else if (sum_big < LIM_LO) begin
            sat_data = W_OUT'(LIM_LO);
            sat_flag = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs; clear forces IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (last_tap) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = last_phase ? S_IDLE : S_MAC;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (clear) begin
            state_nxt = S_IDLE;
        end
    end

    // Delay line, tap/phase counters, accumulator and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x[i] <= '0;
            end
            tap       <= '0;
            phase     <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_phase <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x[i] <= '0;
            end
            tap       <= '0;
            phase     <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_phase <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            for (int i = N_TAPS - 1; i > 0; i--) begin
                x[i] <= x[i-1];
            end
            x[0]  <= in_data;
            tap   <= '0;
            phase <= '0;
            acc   <= '0;
        end else if (state == S_MAC) begin
            if (last_tap) begin
                out_data  <= sat_data;
                out_phase <= phase;
                out_sat   <= sat_flag;
            end else begin
                acc <= sum;
                tap <= tap + 1'b1;
            end
        end else if (handshake && !last_phase) begin
            phase <= phase + 1'b1;
            tap   <= '0;
            acc   <= '0;
        end
    end

    // Coefficient banks; writable only while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_COEF; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_poly_mac.sv
// Randomised bench for fir_poly_mac against an array-based
// convolution model with explicit output clamping.
module tb_fir_poly_mac;

    localparam int W_IN    = 7;
    localparam int W_COEF  = 5;
    localparam int W_OUT   = 10;
    localparam int N_TAPS  = 4;
    localparam int N_PHASE = 2;
    localparam int W_CA    = $clog2(N_PHASE * N_TAPS);
    localparam int W_PH    = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam int HI      = (1 << (W_OUT - 1)) - 1;
    localparam int LO      = -(1 << (W_OUT - 1));

    logic                     clk;
    logic                     rstn;
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic [W_IN-1:0]          in_data;
    logic                     coef_we;
    logic [W_CA-1:0]          coef_addr;
    logic [W_COEF-1:0]        coef_wdata;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [W_OUT-1:0]  out_data;
    logic [W_PH-1:0]          out_phase;
    logic                     out_sat;

    fir_poly_mac #(
        .W_IN   (W_IN),
        .W_COEF (W_COEF),
        .W_OUT  (W_OUT),
        .N_TAPS (N_TAPS),
        .N_PHASE(N_PHASE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int cm   [N_PHASE][N_TAPS];
    int hist [N_TAPS];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_sum(input int p);
        int s;
        s = 0;
        for (int i = 0; i < N_TAPS; i++) begin
            s += hist[i] * cm[p][i];
        end
        return s;
    endfunction

    function automatic int clampv(input int s);
        if (s > HI) return HI;
        if (s < LO) return LO;
        return s;
    endfunction

    function automatic int satv(input int s);
        return ((s > HI) || (s < LO)) ? 1 : 0;
    endfunction

    task automatic push(input int v);
        for (int i = N_TAPS - 1; i > 0; i--) begin
            hist[i] = hist[i-1];
        end
        hist[0] = v;
    endtask

    task automatic wcoef(input int p, input int t, input int v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = W_CA'(p * N_TAPS + t);
        coef_wdata = W_COEF'(v);
        @(posedge clk);
        #1 coef_we = 1'b0;
        cm[p][t] = v;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        for (int i = 0; i < N_TAPS; i++) hist[i] = 0;
        check("clear_busy", busy, 0);
    endtask

    // Feed one sample and collect all phases; optional coefficient write
    // alongside the accept (wi) or during the first MAC cycle (wm), and
    // optional stall cycles of out_ready=0 in every OUT state.
    task automatic run_sample(input int v, input bit wi, input int wp,
                              input int wt, input int wd, input bit wm,
                              input int stall);
        int k;
        int s;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = W_IN'(v);
        if (wi) begin
            coef_we    = 1'b1;
            coef_addr  = W_CA'(wp * N_TAPS + wt);
            coef_wdata = W_COEF'(wd);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (wi) cm[wp][wt] = wd;
        push(v);
        for (int p = 0; p < N_PHASE; p++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                out_ready = (stall == 0);
                coef_we   = (wm && p == 0 && k == 1);
                if (coef_we) begin
                    coef_addr  = '0;
                    coef_wdata = W_COEF'((cm[0][0] == 7) ? -3 : 7);
                end
            end while (!out_valid && k < 100);
            coef_we = 1'b0;
            s = model_sum(p);
            check("latency", k, N_TAPS + 1);
            check("data", out_data, clampv(s));
            check("phase", out_phase, p);
            check("sat", out_sat, satv(s));
            if (stall > 0) begin
                repeat (stall) @(negedge clk);
                check("stall_data", out_data, clampv(s));
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("idle_after", in_ready, 1);
    endtask

    task automatic clear_mid(input int v);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W_IN'(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        for (int i = 0; i < N_TAPS; i++) hist[i] = 0;
        check("cmid_busy", busy, 0);
        check("cmid_in_ready", in_ready, 1);
        check("cmid_valid", out_valid, 0);
    endtask

    task automatic reset_in_out(input int v);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W_IN'(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(out_valid && out_phase == W_PH'(N_PHASE - 1)) && k < 100);
        out_ready = 1'b0;
        check("rst_reach_out", out_valid, 1);
        #1 rstn = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_phase", out_phase, 0);
        check("rst_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < N_PHASE; p++)
            for (int i = 0; i < N_TAPS; i++) cm[p][i] = 0;
        for (int i = 0; i < N_TAPS; i++) hist[i] = 0;
    endtask

    initial begin
        int v;
        rstn       = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        for (int p = 0; p < N_PHASE; p++)
            for (int i = 0; i < N_TAPS; i++) cm[p][i] = 0;
        for (int i = 0; i < N_TAPS; i++) hist[i] = 0;

        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_phase", out_phase, 0);
        check("reset_sat", out_sat, 0);
        rstn = 1'b1;

        // Impulse through bank 0 = {1,2,3,4}.
        for (int i = 0; i < N_TAPS; i++) wcoef(0, i, i + 1);
        run_sample(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) run_sample(0, 0, 0, 0, 0, 0, 0);

        // Two-bank response.
        do_clear();
        for (int i = 0; i < N_TAPS; i++) begin
            wcoef(0, i, 1);
            wcoef(1, i, (i % 2 == 0) ? 1 : -1);
        end
        run_sample(5, 0, 0, 0, 0, 0, 0);
        run_sample(3, 0, 0, 0, 0, 0, 0);

        // Backpressure.
        run_sample(-7, 0, 0, 0, 0, 0, 20);

        // Saturation at both limits.
        for (int p = 0; p < N_PHASE; p++)
            for (int i = 0; i < N_TAPS; i++) wcoef(p, i, -16);
        do_clear();
        for (int n = 0; n < 4; n++) run_sample(-64, 0, 0, 0, 0, 0, 0);
        do_clear();
        run_sample(63, 0, 0, 0, 0, 0, 0);

        // Coefficient guard: ignored while busy, lands with an accept.
        for (int i = 0; i < N_TAPS; i++) wcoef(0, i, 2 - i);
        run_sample(11, 0, 0, 0, 0, 1, 0);
        run_sample(-9, 1, 0, 0, -5, 0, 0);
        run_sample(4, 1, 1, 3, 9, 0, 0);

        // Flush mid-MAC then an impulse.
        clear_mid(37);
        for (int i = 0; i < N_TAPS; i++) wcoef(0, i, i + 1);
        run_sample(1, 0, 0, 0, 0, 0, 0);
        run_sample(0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(2) == 0)
                wcoef($urandom_range(N_PHASE - 1), $urandom_range(N_TAPS - 1),
                      int'($urandom_range(31)) - 16);
            v = int'($urandom_range(127)) - 64;
            run_sample(v, 1'($urandom_range(1)), $urandom_range(N_PHASE - 1),
                       $urandom_range(N_TAPS - 1), int'($urandom_range(31)) - 16,
                       1'($urandom_range(1)), $urandom_range(2));
        end

        // Reset while holding an output; coefficients must read back as 0.
        reset_in_out(23);
        run_sample(50, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
